// File: rtl/divider_seq.sv
// Iterative unsigned restoring divider with a start/done handshake.
// Produces one quotient bit per clock and holds the result until the next accepted start.
module divider_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dsr;
    logic [CW-1:0]    counter;

    logic [WIDTH:0]   acc_shift;
    logic [WIDTH+1:0] trial;
    logic             trial_ok;
    logic [WIDTH-1:0] next_acc;
    logic [WIDTH-1:0] next_q;

    // One restoring step: the extra borrow bit keeps divisors with MSB set exact.
    always_comb begin
        acc_shift = {acc, q[WIDTH-1]};
        trial     = {1'b0, acc_shift} - {2'b00, dsr};
        trial_ok  = ~trial[WIDTH+1];
        next_acc  = trial_ok ? trial[WIDTH-1:0] : acc_shift[WIDTH-1:0];
        next_q    = {q[WIDTH-2:0], trial_ok};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            acc         <= '0;
            q           <= '0;
            dsr         <= '0;
            counter     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                // DONE accepts a new request exactly like IDLE so operations can run back-to-back.
                IDLE, DONE: begin
                    if (start) begin
                        busy <= 1'b1;
                        dsr  <= divisor;
                        if (divisor == '0) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state       <= RUN;
                            counter     <= LAST_COUNT;
                            acc         <= '0;
                            q           <= dividend;
                            div_by_zero <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    acc <= next_acc;
                    q   <= next_q;
                    if (counter == '0) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        quotient  <= next_q;
                        remainder <= next_acc;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
